// File: rtl/stepper_pkg.sv
// Shared constants for the stepper axis controller: register map, control and
// command bit positions, the eight-entry coil phase table and a byte-lane merge helper.
package stepper_pkg;

  // Per-channel register offsets.
  localparam logic [2:0] OFF_CTRL       = 3'd0;
  localparam logic [2:0] OFF_STATUS     = 3'd1;
  localparam logic [2:0] OFF_PERIOD     = 3'd2;
  localparam logic [2:0] OFF_COUNT      = 3'd3;
  localparam logic [2:0] OFF_POSITION   = 3'd4;
  localparam logic [2:0] OFF_PWM_PERIOD = 3'd5;
  localparam logic [2:0] OFF_DUTY_A     = 3'd6;
  localparam logic [2:0] OFF_DUTY_B     = 3'd7;

  // CTRL register bits.
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_DIR    = 1;
  localparam int unsigned CTRL_HALF   = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;

  // CMD (write side of STATUS) bits.
  localparam int unsigned CMD_START    = 0;
  localparam int unsigned CMD_STOP     = 1;
  localparam int unsigned CMD_DONE_CLR = 2;

  // Phase index -> {ax, ay, bx, by}, active high.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b0001, 4'b0101, 4'b0100, 4'b0110, 4'b0010, 4'b1010, 4'b1000
  };

  // Replace the byte lanes of old_val selected by byteen with those of new_val.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  byteen);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = byteen[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/stepper_channel.sv
// One motor channel: register file, step timer, step/position counters, phase
// index, coil PWM and the registered active-low H-bridge drives.
module stepper_channel
  import stepper_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned PWM_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [2:0]  offset,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic        irq_req,
  output logic        ax_n,
  output logic        ay_n,
  output logic        bx_n,
  output logic        by_n,
  output logic        ae_n,
  output logic        be_n
);

  logic [3:0]           ctrl_q, ctrl_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] pos_q, pos_d;
  logic [CNT_WIDTH-1:0] timer_q, timer_d;
  logic [2:0]           idx_q, idx_d;
  logic [PWM_WIDTH-1:0] pwm_period_q, pwm_period_d;
  logic [PWM_WIDTH-1:0] duty_a_q, duty_a_d;
  logic [PWM_WIDTH-1:0] duty_b_q, duty_b_d;
  logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;

  logic                 wr_ctrl, wr_cmd, start_req, stop_req, clr_req;
  logic [31:0]          merged;
  logic [CNT_WIDTH-1:0] reload;
  logic [2:0]           inc;
  logic                 pwm_a, pwm_b;
  logic [3:0]           phase;

  assign wr_ctrl   = wr && (offset == OFF_CTRL) && byteen[0];
  assign wr_cmd    = wr && (offset == OFF_STATUS) && byteen[0];
  // STOP wins over START in the same write.
  assign start_req = wr_cmd && wdata[CMD_START] && !wdata[CMD_STOP];
  assign stop_req  = wr_cmd && wdata[CMD_STOP];
  assign clr_req   = wr_cmd && wdata[CMD_DONE_CLR];

  // The readback value of the addressed register is the base for byte-lane merging.
  assign merged  = be_merge(rdata, wdata, byteen);
  assign reload  = (period_q == '0) ? '0 : period_q - CNT_WIDTH'(1);
  assign inc     = ctrl_q[CTRL_HALF] ? 3'd1 : 3'd2;
  assign pwm_a   = pwm_cnt_q < duty_a_q;
  assign pwm_b   = pwm_cnt_q < duty_b_q;
  assign phase   = PHASE_TABLE[idx_q];
  assign irq_req = done_q & ctrl_q[CTRL_IRQ_EN];

  // Register readback for the addressed offset; unused bits read as zero.
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_CTRL:       rdata = {28'd0, ctrl_q};
      OFF_STATUS:     rdata = {30'd0, done_q, busy_q};
      OFF_PERIOD:     rdata = 32'(period_q);
      OFF_COUNT:      rdata = 32'(count_q);
      OFF_POSITION:   rdata = 32'(pos_q);
      OFF_PWM_PERIOD: rdata = 32'(pwm_period_q);
      OFF_DUTY_A:     rdata = 32'(duty_a_q);
      OFF_DUTY_B:     rdata = 32'(duty_b_q);
      default:        rdata = '0;
    endcase
  end

  // Next-state: bus writes, then the step generator, then the PWM counter.
  always_comb begin
    ctrl_d       = ctrl_q;
    busy_d       = busy_q;
    done_d       = done_q;
    period_d     = period_q;
    count_d      = count_q;
    pos_d        = pos_q;
    timer_d      = timer_q;
    idx_d        = idx_q;
    pwm_period_d = pwm_period_q;
    duty_a_d     = duty_a_q;
    duty_b_d     = duty_b_q;

    if (wr_ctrl) begin
      ctrl_d = wdata[3:0];
      // Step size is frozen for the duration of a move.
      if (busy_q) ctrl_d[CTRL_HALF] = ctrl_q[CTRL_HALF];
    end
    if (wr && offset == OFF_PERIOD)              period_d     = CNT_WIDTH'(merged);
    if (wr && offset == OFF_COUNT && !busy_q)    count_d      = CNT_WIDTH'(merged);
    if (wr && offset == OFF_POSITION && !busy_q) pos_d        = CNT_WIDTH'(merged);
    if (wr && offset == OFF_PWM_PERIOD)          pwm_period_d = PWM_WIDTH'(merged);
    if (wr && offset == OFF_DUTY_A)              duty_a_d     = PWM_WIDTH'(merged);
    if (wr && offset == OFF_DUTY_B)              duty_b_d     = PWM_WIDTH'(merged);

    if (clr_req) done_d = 1'b0;

    if (busy_q) begin
      if (stop_req) begin
        busy_d = 1'b0;
      end else if (timer_q == '0) begin
        idx_d   = ctrl_q[CTRL_DIR] ? idx_q + inc : idx_q - inc;
        pos_d   = ctrl_q[CTRL_DIR] ? pos_q + CNT_WIDTH'(1) : pos_q - CNT_WIDTH'(1);
        count_d = count_q - CNT_WIDTH'(1);
        timer_d = reload;
        if (count_q == CNT_WIDTH'(1)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end else begin
        timer_d = timer_q - CNT_WIDTH'(1);
      end
    end else if (start_req) begin
      if (count_q == '0) begin
        done_d = 1'b1;
      end else begin
        busy_d  = 1'b1;
        timer_d = reload;
      end
    end

    // Compare uses the current period so a lowered period wraps the counter at once.
    pwm_cnt_d = (pwm_cnt_q >= pwm_period_q) ? '0 : pwm_cnt_q + PWM_WIDTH'(1);
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      period_q     <= '0;
      count_q      <= '0;
      pos_q        <= '0;
      timer_q      <= '0;
      idx_q        <= '0;
      pwm_period_q <= '1;
      duty_a_q     <= '0;
      duty_b_q     <= '0;
      pwm_cnt_q    <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      period_q     <= period_d;
      count_q      <= count_d;
      pos_q        <= pos_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      pwm_period_q <= pwm_period_d;
      duty_a_q     <= duty_a_d;
      duty_b_q     <= duty_b_d;
      pwm_cnt_q    <= pwm_cnt_d;
    end
  end

  // Registered active-low bridge drives; all off in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ax_n <= 1'b1;
      ay_n <= 1'b1;
      bx_n <= 1'b1;
      by_n <= 1'b1;
      ae_n <= 1'b1;
      be_n <= 1'b1;
    end else begin
      ax_n <= ~(ctrl_q[CTRL_EN] & phase[3] & pwm_a);
      ay_n <= ~(ctrl_q[CTRL_EN] & phase[2] & pwm_a);
      bx_n <= ~(ctrl_q[CTRL_EN] & phase[1] & pwm_b);
      by_n <= ~(ctrl_q[CTRL_EN] & phase[0] & pwm_b);
      ae_n <= ~ctrl_q[CTRL_EN];
      be_n <= ~ctrl_q[CTRL_EN];
    end
  end

endmodule

// File: rtl/stepper_axis_controller.sv
// Multi-channel stepper controller: Avalon-MM decode, per-channel instances,
// registered readback and registered interrupt.
module stepper_axis_controller
  import stepper_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned PWM_WIDTH = 16
) (
  input  logic                          csi_MCLK_clk,
  input  logic                          rsi_MRST_reset,
  input  logic [$clog2(CHANNELS)+2:0]   avs_ctrl_address,
  input  logic [31:0]                   avs_ctrl_writedata,
  input  logic [3:0]                    avs_ctrl_byteenable,
  input  logic                          avs_ctrl_write,
  input  logic                          avs_ctrl_read,
  output logic [31:0]                   avs_ctrl_readdata,
  output logic                          avs_ctrl_waitrequest,
  output logic                          ins_irq_irq,
  output logic [CHANNELS-1:0]           AX,
  output logic [CHANNELS-1:0]           AY,
  output logic [CHANNELS-1:0]           BX,
  output logic [CHANNELS-1:0]           BY,
  output logic [CHANNELS-1:0]           AE,
  output logic [CHANNELS-1:0]           BE
);

  localparam int unsigned SelW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned AddrW = $clog2(CHANNELS) + 3;

  logic [SelW-1:0]     ch_sel;
  logic                ch_valid;
  logic [2:0]          offset;
  logic [31:0]         ch_rdata [CHANNELS];
  logic [CHANNELS-1:0] irq_req;
  logic [31:0]         rd_mux;
  logic [31:0]         readdata_q;
  logic                irq_q;

  assign offset = avs_ctrl_address[2:0];

  if (CHANNELS > 1) begin : g_sel
    assign ch_sel = avs_ctrl_address[AddrW-1:3];
  end else begin : g_sel_single
    assign ch_sel = '0;
  end

  // Non-power-of-two channel counts leave holes in the map that read as zero.
  assign ch_valid = 32'(ch_sel) < CHANNELS;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    stepper_channel #(
      .CNT_WIDTH(CNT_WIDTH),
      .PWM_WIDTH(PWM_WIDTH)
    ) u_channel (
      .clk    (csi_MCLK_clk),
      .rst    (rsi_MRST_reset),
      .wr     (avs_ctrl_write && ch_valid && (ch_sel == SelW'(i))),
      .offset (offset),
      .wdata  (avs_ctrl_writedata),
      .byteen (avs_ctrl_byteenable),
      .rdata  (ch_rdata[i]),
      .irq_req(irq_req[i]),
      .ax_n   (AX[i]),
      .ay_n   (AY[i]),
      .bx_n   (BX[i]),
      .by_n   (BY[i]),
      .ae_n   (AE[i]),
      .be_n   (BE[i])
    );
  end

  assign rd_mux = ch_valid ? ch_rdata[ch_sel] : '0;

  // Read latency of one; idle cycles return zero.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      readdata_q <= avs_ctrl_read ? rd_mux : '0;
      irq_q      <= |irq_req;
    end
  end

  assign avs_ctrl_readdata    = readdata_q;
  assign ins_irq_irq          = irq_q;
  assign avs_ctrl_waitrequest = 1'b0;

endmodule

// File: doc/stepper_axis_controller.md
Name: stepper_axis_controller

Overview:
- Multi-channel stepper motor controller; Avalon-MM slave on the system bus.
- Each channel has its own autonomous step generator: programmable step period and step count, direction, full/half-step mode, position counter.
- Each channel chops its coil A and coil B drives with independent PWM duties, with done/IRQ reporting.
- Single clock domain; drives active-low H-bridge inputs per channel.

Parameters:
- CHANNELS, 2, number of motor channels (1..8).
- CNT_WIDTH, 32, width of step period, step count and position registers.
- PWM_WIDTH, 16, width of PWM counter, period and duties.

Ports:
- csi_MCLK_clk  in  1  system clock.
- rsi_MRST_reset  in  1  asynchronous, active-high reset.
- avs_ctrl_address  in  $clog2(CHANNELS)+3  {channel, reg offset}.
- avs_ctrl_writedata  in  32  write data.
- avs_ctrl_byteenable  in  4  byte enables.
- avs_ctrl_write  in  1  write strobe.
- avs_ctrl_read  in  1  read strobe.
- avs_ctrl_readdata  out  32  registered read data.
- avs_ctrl_waitrequest  out  1  tied 0.
- ins_irq_irq  out  1  OR over channels of DONE&IRQ_EN, registered.
- AX, AY, BX, BY  out  CHANNELS  active-low coil drives, one bit per channel.
- AE, BE  out  CHANNELS  active-low bridge enables, one bit per channel.

Behaviour:
- Register map per channel (offset):
  - 0 CTRL RW: [0] EN, [1] DIR (1 = index+), [2] HALF, [3] IRQ_EN.
  - 1 STATUS/CMD: read {DONE[1], BUSY[0]}; write [0] START, [1] STOP, [2] DONE W1C.
  - 2 STEP_PERIOD: clocks per step.
  - 3 STEP_COUNT: write loads steps; read returns remaining.
  - 4 POSITION: signed.
  - 5 PWM_PERIOD.
  - 6 DUTY_A.
  - 7 DUTY_B.
- Byte enables apply to offsets 2..7. CTRL/CMD use byte 0 only. Unused bits read 0.
- Reads: readdata valid 1 cycle after read (read latency 1). Reads with no effect return 0. Writes take effect on the next edge.
- Reset values:
  - All registers 0 except PWM_PERIOD = all ones.
  - Phase index 0, BUSY=0, DONE=0, irq 0, readdata 0.
  - All coil/enable outputs 1 (off).
- Phase table, index -> {ax,ay,bx,by} active-high: 0:1000, 1:1010, 2:0010, 3:0110, 4:0100, 5:0101, 6:0001, 7:1001.
- Step advance: index ±1 (HALF=1) or ±2 (HALF=0), modulo 8. Parity is preserved in full-step mode.
- START, accepted only when BUSY=0:
  - STEP_COUNT=0: DONE=1 next cycle, no step.
  - Otherwise BUSY=1 and timer loads max(STEP_PERIOD,1)-1.
- While BUSY, each cycle timer==0:
  - Advance phase; POSITION ±1 per DIR; STEP_COUNT-1; reload timer.
  - If STEP_COUNT reaches 0: BUSY=0 and DONE=1 that same edge.
  - First step occurs max(STEP_PERIOD,1) cycles after the START write edge.
- STOP: BUSY=0 next edge, no further steps, DONE unchanged, STEP_COUNT keeps the remainder.
- START+STOP in the same write: STOP wins.
- DONE set and W1C in the same cycle: set wins.
- While BUSY, writes to STEP_COUNT, POSITION and HALF are ignored. DIR and STEP_PERIOD changes apply from the next reload.
- POSITION wraps two's-complement at CNT_WIDTH.
- PWM, per channel:
  - Counter runs 0..PWM_PERIOD, then wraps to 0.
  - pwm_a = cnt < DUTY_A; pwm_b = cnt < DUTY_B.
  - DUTY=0 gives always off; DUTY>PWM_PERIOD gives always on.
  - Writing PWM_PERIOD below the current count wraps the counter to 0 next cycle.
- Outputs, registered, 1 cycle after phase/PWM state:
  - AE = BE = ~EN.
  - AX = ~(EN & ax & pwm_a), AY = ~(EN & ay & pwm_a).
  - BX = ~(EN & bx & pwm_b), BY = ~(EN & by & pwm_b).
  - EN=0 does not stop the step generator. Phase and position still advance.
- Reset mid-operation aborts everything immediately to reset values.

Decomposition:
- Package stepper_pkg holds:
  - 8-entry phase table constant.
  - Register offset localparams.
  - CTRL/CMD bit index localparams.
- Sub-module stepper_channel: one channel's timer, counters, phase, PWM and registered outputs. The top generates CHANNELS instances and does bus decode, readback mux and irq OR.

Test Plan:
- Reset, then read all channel-0 regs -> PWM_PERIOD=0xFFFF, others 0; all outputs 1.
- ch0: CTRL=0x3 (EN, DIR, full), PERIOD=4, COUNT=3, PWM_PERIOD=0xFFFF, DUTY_A=DUTY_B=0x10000 (PWM_WIDTH=17 build, or PERIOD=9/DUTY=10), START -> steps 4, 8, 12 cycles after start; index 0→2→4→6; POSITION=3; BUSY falls with DONE=1 on step 3; coils follow table.
- HALF=1, DIR=0, from index 0, COUNT=2 -> index 7 then 6; POSITION=-2 (0xFFFFFFFE).
- PWM_PERIOD=9, DUTY_A=3, index 0 -> AX low 3 of every 10 cycles; DUTY_A=0 -> AX stays 1.
- COUNT=100, START, STOP after 10 steps -> BUSY=0, DONE=0, STEP_COUNT reads 90; START again completes 90 more steps.
- ch1 IRQ_EN=1, COUNT=0, START -> DONE=1, irq=1; W1C DONE -> irq 0; simultaneous START+STOP -> nothing starts.
